// File: rtl/tcp_recv_engine.sv
// tcp_recv_engine
//   Receive-side benchmark engine for the TCP offload path. Accepts session
//   notifications and issues the matching read request. It then takes the RX
//   metadata and the payload beats, and checks the incrementing pattern that
//   the TX benchmark sender produces. Message, word and error counters are
//   exported on status_reg.
//
// Ports
//   clk, rstn                     single clock, synchronous active-low reset
//   s_axis_notification_*         {length[31:16], session[15:0]} notifications
//   m_axis_read_package_*         read request, same format as notification
//   s_axis_rx_metadata_*          session of the data that follows
//   s_axis_rx_data_*              payload beats (data/keep/last)
//   control_reg                   [2] ops, [3] offset, [7][2] start, [4][0] check en
//   status_reg                    [0] th_cnt [1] msg_cnt [2] word_cnt
//                                 [3] data_err_cnt [4] len_err_cnt
//                                 [5] sess_err_cnt [6] first error loc [7] notif_cnt
module tcp_recv_engine #(
  parameter int DATA_WIDTH = 512,
  parameter bit CHECK_EN   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      s_axis_notification_valid,
  output logic                      s_axis_notification_ready,
  input  logic [31:0]               s_axis_notification_data,
  output logic                      m_axis_read_package_valid,
  input  logic                      m_axis_read_package_ready,
  output logic [31:0]               m_axis_read_package_data,
  input  logic                      s_axis_rx_metadata_valid,
  output logic                      s_axis_rx_metadata_ready,
  input  logic [15:0]               s_axis_rx_metadata_data,
  input  logic                      s_axis_rx_data_valid,
  output logic                      s_axis_rx_data_ready,
  input  logic [DATA_WIDTH-1:0]     s_axis_rx_data_data,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_rx_data_keep,
  input  logic                      s_axis_rx_data_last,
  input  logic [15:0][31:0]         control_reg,
  output logic [7:0][31:0]          status_reg
);

  typedef enum logic [1:0] {IDLE, READ_REQ, META, DATA} state_t;

  state_t state_q, state_d;

  logic [31:0] ops_r, offset_r;
  logic        start_r, start_rr, chk_r;
  logic        start_pulse;
  logic        active;

  logic [15:0] cap_sess, cap_len;
  logic [31:0] word_idx;
  logic [31:0] th_cnt, msg_cnt, word_cnt, data_err_cnt, len_err_cnt;
  logic [31:0] sess_err_cnt, err_loc, notif_cnt;
  logic        err_seen, run, armed;

  logic        notif_hs, read_hs, meta_hs, data_hs;
  logic        notif_empty, mismatch, len_bad;
  logic [31:0] exp_word;

  // keep is deliberately not checked; payload bits are only read when the
  // checker is built in, so everything goes through this sink.
  logic unused_bits;
  assign unused_bits = ^{s_axis_rx_data_keep, s_axis_rx_data_data, control_reg};

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign start_pulse = start_r & ~start_rr;

  assign notif_hs = s_axis_notification_valid & s_axis_notification_ready;
  assign read_hs  = m_axis_read_package_valid & m_axis_read_package_ready;
  assign meta_hs  = s_axis_rx_metadata_valid & s_axis_rx_metadata_ready;
  assign data_hs  = s_axis_rx_data_valid & s_axis_rx_data_ready;

  assign notif_empty = (s_axis_notification_data[31:22] == '0);
  assign exp_word    = word_idx + offset_r;
  assign mismatch    = CHECK_EN && chk_r &&
                       (s_axis_rx_data_data != {{(DATA_WIDTH-32){1'b0}}, exp_word});
  assign len_bad     = (word_idx + 32'd1) != {22'd0, cap_len[15:6]};

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Handshake outputs are decoded from the state but held low until the
  // cycle after reset is released.
  always_comb begin
    state_d                   = state_q;
    s_axis_notification_ready = 1'b0;
    m_axis_read_package_valid = 1'b0;
    s_axis_rx_metadata_ready  = 1'b0;
    s_axis_rx_data_ready      = 1'b0;
    m_axis_read_package_data  = {cap_len, cap_sess};
    case (state_q)
      IDLE: begin
        s_axis_notification_ready = active;
        if (notif_hs && !notif_empty) state_d = READ_REQ;
      end
      READ_REQ: begin
        m_axis_read_package_valid = active;
        if (read_hs) state_d = META;
      end
      META: begin
        s_axis_rx_metadata_ready = active;
        if (meta_hs) state_d = DATA;
      end
      DATA: begin
        s_axis_rx_data_ready = active;
        if (data_hs && s_axis_rx_data_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ops_r        <= '0;
      offset_r     <= '0;
      start_r      <= 1'b0;
      start_rr     <= 1'b0;
      chk_r        <= 1'b0;
      active       <= 1'b0;
      cap_sess     <= '0;
      cap_len      <= '0;
      word_idx     <= '0;
      th_cnt       <= '0;
      msg_cnt      <= '0;
      word_cnt     <= '0;
      data_err_cnt <= '0;
      len_err_cnt  <= '0;
      sess_err_cnt <= '0;
      err_loc      <= '0;
      notif_cnt    <= '0;
      err_seen     <= 1'b0;
      run          <= 1'b0;
      armed        <= 1'b0;
    end else begin
      ops_r    <= control_reg[2];
      offset_r <= control_reg[3];
      start_r  <= control_reg[7][2];
      start_rr <= start_r;
      chk_r    <= control_reg[4][0];
      active   <= 1'b1;

      if (notif_hs) begin
        if (notif_empty) begin
          notif_cnt <= sat_inc(notif_cnt);
        end else begin
          cap_sess <= s_axis_notification_data[15:0];
          cap_len  <= s_axis_notification_data[31:16];
        end
      end

      if (data_hs) word_idx <= s_axis_rx_data_last ? '0 : word_idx + 32'd1;

      // start_pulse takes priority: an event landing on the same edge is lost.
      if (start_pulse) begin
        th_cnt       <= '0;
        msg_cnt      <= '0;
        word_cnt     <= '0;
        data_err_cnt <= '0;
        len_err_cnt  <= '0;
        sess_err_cnt <= '0;
        err_seen     <= 1'b0;
        run          <= 1'b0;
        armed        <= 1'b1;
      end else begin
        if (meta_hs && (s_axis_rx_metadata_data != cap_sess))
          sess_err_cnt <= sat_inc(sess_err_cnt);
        if (data_hs) begin
          word_cnt <= sat_inc(word_cnt);
          if (s_axis_rx_data_last) begin
            msg_cnt <= sat_inc(msg_cnt);
            if (len_bad) len_err_cnt <= sat_inc(len_err_cnt);
          end
          if (mismatch) begin
            data_err_cnt <= sat_inc(data_err_cnt);
            if (!err_seen) begin
              err_seen <= 1'b1;
              err_loc  <= {msg_cnt[15:0], word_idx[15:0]};
            end
          end
          if (armed) begin
            run   <= 1'b1;
            armed <= 1'b0;
          end
        end
        if (run && (ops_r != '0) && (msg_cnt != ops_r))
          th_cnt <= sat_inc(th_cnt);
      end
    end
  end

  always_comb begin
    status_reg    = '0;
    status_reg[0] = th_cnt;
    status_reg[1] = msg_cnt;
    status_reg[2] = word_cnt;
    status_reg[3] = data_err_cnt;
    status_reg[4] = len_err_cnt;
    status_reg[5] = sess_err_cnt;
    status_reg[6] = err_loc;
    status_reg[7] = notif_cnt;
  end

endmodule

// File: tb/tb_tcp_recv_engine.sv
// Testbench for tcp_recv_engine: read requests are checked by a scoreboard
// queue filled when notifications are sent; status expectations are queued
// with each scenario and drained against status_reg.
module tb_tcp_recv_engine;

  localparam int DW  = 512;
  localparam int BUD = 500;

  logic            clk = 1'b0;
  logic            rstn;
  logic            notif_valid, notif_ready;
  logic [31:0]     notif_data;
  logic            rd_valid, rd_ready;
  logic [31:0]     rd_data;
  logic            meta_valid, meta_ready;
  logic [15:0]     meta_data;
  logic            rx_valid, rx_ready, rx_last;
  logic [DW-1:0]   rx_data;
  logic [DW/8-1:0] rx_keep;
  logic [15:0][31:0] ctrl;
  logic [7:0][31:0]  status;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned first_cyc, last_cyc;
  bit          bp_en = 1'b1;

  typedef struct {
    string       tag;
    int          idx;
    logic [31:0] val;
  } st_exp_t;

  st_exp_t     sq[$];
  logic [31:0] rq[$];

  tcp_recv_engine #(.DATA_WIDTH(DW), .CHECK_EN(1'b1)) dut (
    .clk                       (clk),
    .rstn                      (rstn),
    .s_axis_notification_valid (notif_valid),
    .s_axis_notification_ready (notif_ready),
    .s_axis_notification_data  (notif_data),
    .m_axis_read_package_valid (rd_valid),
    .m_axis_read_package_ready (rd_ready),
    .m_axis_read_package_data  (rd_data),
    .s_axis_rx_metadata_valid  (meta_valid),
    .s_axis_rx_metadata_ready  (meta_ready),
    .s_axis_rx_metadata_data   (meta_data),
    .s_axis_rx_data_valid      (rx_valid),
    .s_axis_rx_data_ready      (rx_ready),
    .s_axis_rx_data_data       (rx_data),
    .s_axis_rx_data_keep       (rx_keep),
    .s_axis_rx_data_last       (rx_last),
    .control_reg               (ctrl),
    .status_reg                (status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Random backpressure on the read request channel.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 rd_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Read request monitor: pops the scoreboard on each handshake and checks
  // that a stalled request holds its data.
  logic        stalled = 1'b0;
  logic [31:0] held;
  always @(negedge clk) begin
    if (rstn) begin
      if (stalled) chk("rd_stable", rd_data, held);
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0) chk("rd_unexpected", rd_data, 32'hx);
        else chk("rd_req", rd_data, rq.pop_front());
      end
      stalled = rd_valid && !rd_ready;
      held    = rd_data;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic expect_st(input string tag, input int idx, input logic [31:0] v);
    st_exp_t e;
    e.tag = tag; e.idx = idx; e.val = v;
    sq.push_back(e);
  endtask

  task automatic drain();
    st_exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    while (sq.size() != 0) begin
      e = sq.pop_front();
      chk(e.tag, status[e.idx], e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_notif(input logic [15:0] sess, input logic [15:0] len);
    bit hs = 1'b0;
    notif_valid = 1'b1;
    notif_data  = {len, sess};
    if (len[15:6] != '0) rq.push_back({len, sess});
    for (int n = 0; n < BUD && !hs; n++) begin
      @(negedge clk); hs = notif_ready;
      @(posedge clk); #1;
    end
    notif_valid = 1'b0;
    if (!hs) chk("timeout_notif", 32'd0, 32'd1);
  endtask

  task automatic send_meta(input logic [15:0] sess);
    bit hs = 1'b0;
    meta_valid = 1'b1;
    meta_data  = sess;
    for (int n = 0; n < BUD && !hs; n++) begin
      @(negedge clk); hs = meta_ready;
      @(posedge clk); #1;
    end
    meta_valid = 1'b0;
    if (!hs) chk("timeout_meta", 32'd0, 32'd1);
  endtask

  task automatic send_beat(input logic [31:0] w, input bit lst);
    bit hs = 1'b0;
    rx_valid = 1'b1;
    rx_data  = '0;
    rx_data[31:0] = w;
    rx_last  = lst;
    for (int n = 0; n < BUD && !hs; n++) begin
      @(negedge clk); hs = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    if (!hs) chk("timeout_beat", 32'd0, 32'd1);
  endtask

  // One message; beat index bad_idx carries bad_val instead of the pattern.
  task automatic send_msg(input logic [15:0] sess, input logic [15:0] len,
                          input logic [15:0] msess, input int nbeats,
                          input int bad_idx, input logic [31:0] bad_val,
                          input bit rec_first, input bit rec_last);
    send_notif(sess, len);
    send_meta(msess);
    for (int i = 0; i < nbeats; i++) begin
      send_beat((i == bad_idx) ? bad_val : 32'h100 + 32'(i), i == nbeats - 1);
      if (rec_first && i == 0) first_cyc = cyc;
      if (rec_last && i == nbeats - 1) last_cyc = cyc;
    end
  endtask

  task automatic restart();
    ctrl[7][2] = 1'b0;
    repeat (4) @(posedge clk);
    #1 ctrl[7][2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    notif_valid = 1'b0; notif_data = '0;
    meta_valid = 1'b0;  meta_data = '0;
    rx_valid = 1'b0; rx_data = '0; rx_keep = '1; rx_last = 1'b0;
    ctrl = '0;
    ctrl[2] = 32'd4;
    ctrl[3] = 32'h100;
    ctrl[4][0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_notif_rdy", 32'(notif_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 8; i++) expect_st($sformatf("rst_st%0d", i), i, 32'd0);
    drain();
    rstn = 1'b1;
    @(posedge clk); #1;
    ctrl[7][2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 1: four clean messages, throughput counter freezes at ops
    for (int m = 0; m < 4; m++)
      send_msg(16'd5, 16'd256, 16'd5, 4, -1, 32'd0, m == 0, m == 3);
    expect_st("t1_msg", 1, 32'd4);
    expect_st("t1_word", 2, 32'd16);
    expect_st("t1_derr", 3, 32'd0);
    expect_st("t1_lerr", 4, 32'd0);
    expect_st("t1_serr", 5, 32'd0);
    expect_st("t1_th", 0, last_cyc - first_cyc);
    drain();
    repeat (10) @(posedge clk);
    #1;
    expect_st("t1_th_frozen", 0, last_cyc - first_cyc);
    drain();

    // 2: corrupted word 2 of message 1
    restart();
    send_msg(16'd5, 16'd256, 16'd5, 4, -1, 32'd0, 1'b0, 1'b0);
    send_msg(16'd5, 16'd256, 16'd5, 4, 2, 32'hDEAD, 1'b0, 1'b0);
    expect_st("t2_derr", 3, 32'd1);
    expect_st("t2_loc", 6, 32'h0001_0002);
    expect_st("t2_msg", 1, 32'd2);
    expect_st("t2_word", 2, 32'd8);
    drain();

    // 3: length 512 but last on beat 6
    restart();
    send_msg(16'd5, 16'd512, 16'd5, 6, -1, 32'd0, 1'b0, 1'b0);
    expect_st("t3_lerr", 4, 32'd1);
    expect_st("t3_msg", 1, 32'd1);
    expect_st("t3_word", 2, 32'd6);
    expect_st("t3_derr", 3, 32'd0);
    drain();
    @(negedge clk);
    chk("t3_idle", 32'(notif_ready), 32'd1);
    @(posedge clk); #1;

    // 4: metadata session differs from the requested one
    restart();
    send_msg(16'd7, 16'd256, 16'd9, 4, -1, 32'd0, 1'b0, 1'b0);
    expect_st("t4_serr", 5, 32'd1);
    expect_st("t4_msg", 1, 32'd1);
    expect_st("t4_word", 2, 32'd4);
    expect_st("t4_lerr", 4, 32'd0);
    drain();

    // 5: sub-word notification is dropped
    send_notif(16'd5, 16'd32);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rd", 32'(rd_valid), 32'd0);
      chk("t5_idle", 32'(notif_ready), 32'd1);
    end
    @(posedge clk); #1;
    expect_st("t5_notif", 7, 32'd1);
    expect_st("t5_msg", 1, 32'd1);
    drain();

    // 6: reset in the middle of a message, then a fresh one
    restart();
    send_notif(16'd3, 16'd512);
    send_meta(16'd3);
    send_beat(32'h100, 1'b0);
    send_beat(32'h101, 1'b0);
    rx_valid = 1'b1; rx_data = '0; rx_data[31:0] = 32'h102;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rx_rdy_rst", 32'(rx_ready), 32'd0);
    chk("t6_notif_rdy_rst", 32'(notif_ready), 32'd0);
    chk("t6_rd_valid_rst", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_msg(16'd3, 16'd512, 16'd3, 8, -1, 32'd0, 1'b0, 1'b0);
    expect_st("t6_msg", 1, 32'd1);
    expect_st("t6_word", 2, 32'd8);
    expect_st("t6_derr", 3, 32'd0);
    expect_st("t6_lerr", 4, 32'd0);
    expect_st("t6_serr", 5, 32'd0);
    expect_st("t6_loc", 6, 32'd0);
    expect_st("t6_notif", 7, 32'd0);
    drain();
    chk("rd_queue_empty", 32'(rq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
